// File: rtl/key_event_gen.sv
// Debounced push-button event generator: turns a raw active-low key into clean
// press/release/long/repeat strobes plus a wrapping 8-bit press counter.
module key_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic       key_ni,
  input  logic       clr_i,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       held_o,
  output logic [7:0] press_cnt_o
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HoldW = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned RepW  = $clog2(REPEAT_CYCLES) + 1;

  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StHeld,
    StLong,
    StDbRel
  } state_e;

  state_e           state;
  logic             sync1;
  logic             key_s;
  logic             from_long;
  logic [DbW-1:0]   db_cnt;
  logic [HoldW-1:0] hold_cnt;
  logic [RepW-1:0]  rep_cnt;

  logic [DbW-1:0]   db_inc;
  logic [HoldW-1:0] hold_inc;
  logic [RepW-1:0]  rep_inc;
  logic             db_done;
  logic             hold_done;
  logic             rep_done;

  always_comb begin
    db_inc    = db_cnt + DbW'(1);
    hold_inc  = hold_cnt + HoldW'(1);
    rep_inc   = rep_cnt + RepW'(1);
    db_done   = (db_inc == DbMax);
    hold_done = (hold_inc == HoldMax);
    rep_done  = (rep_inc == RepMax);
  end

  always_ff @(posedge clk100_i or posedge rstn_i) begin
    if (rstn_i) begin
      state       <= StIdle;
      sync1       <= 1'b0;
      key_s       <= 1'b0;
      from_long   <= 1'b0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
      long_o      <= 1'b0;
      repeat_o    <= 1'b0;
      held_o      <= 1'b0;
      press_cnt_o <= '0;
    end else begin
      sync1     <= ~key_ni;
      key_s     <= sync1;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      if (clr_i) press_cnt_o <= '0;

      case (state)
        StIdle: begin
          if (key_s) begin
            state  <= StDbPress;
            db_cnt <= DbW'(1);
          end
        end

        StDbPress: begin
          if (!key_s) begin
            state <= StIdle;
          end else if (db_done) begin
            state    <= StHeld;
            press_o  <= 1'b1;
            held_o   <= 1'b1;
            hold_cnt <= '0;
            if (!clr_i) press_cnt_o <= press_cnt_o + 8'd1;
          end else begin
            db_cnt <= db_inc;
          end
        end

        StHeld: begin
          if (!key_s) begin
            state     <= StDbRel;
            db_cnt    <= DbW'(1);
            from_long <= 1'b0;
          end else if (hold_done) begin
            state   <= StLong;
            long_o  <= 1'b1;
            rep_cnt <= '0;
          end else begin
            hold_cnt <= hold_inc;
          end
        end

        StLong: begin
          if (!key_s) begin
            state     <= StDbRel;
            db_cnt    <= DbW'(1);
            from_long <= 1'b1;
          end else if (rep_done) begin
            repeat_o <= 1'b1;
            rep_cnt  <= '0;
          end else begin
            rep_cnt <= rep_inc;
          end
        end

        StDbRel: begin
          // A rejected glitch resumes the recorded state and takes that state's step
          // on the same edge, so the frozen cycles are exactly the low ones.
          if (key_s) begin
            if (from_long) begin
              state <= StLong;
              if (rep_done) begin
                repeat_o <= 1'b1;
                rep_cnt  <= '0;
              end else begin
                rep_cnt <= rep_inc;
              end
            end else if (hold_done) begin
              state   <= StLong;
              long_o  <= 1'b1;
              rep_cnt <= '0;
            end else begin
              state    <= StHeld;
              hold_cnt <= hold_inc;
            end
          end else if (db_done) begin
            state     <= StIdle;
            release_o <= 1'b1;
            held_o    <= 1'b0;
          end else begin
            db_cnt <= db_inc;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with DEBOUNCE=4, LONG=20, REPEAT=5.
module tb_key_event_gen;

  logic       clk100_i = 1'b0;
  logic       rstn_i;
  logic       key_ni;
  logic       clr_i;
  logic       press_o;
  logic       release_o;
  logic       long_o;
  logic       repeat_o;
  logic       held_o;
  logic [7:0] press_cnt_o;

  int total = 0;
  int bad   = 0;
  int multi_n = 0;

  // Event log filled by scan; tick indices are relative to the last scan_clear.
  // A key change driven just after tick k is first sampled by edge k+1, so an event
  // that is "5 edges after the fall" appears at tick index 6 here.
  int idx, p_n, p_at, r_n, r_at, l_n, l_at, rep_n, rep_at1, rep_at2, h_n;

  key_event_gen #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk100_i   (clk100_i),
    .rstn_i     (rstn_i),
    .key_ni     (key_ni),
    .clr_i      (clr_i),
    .press_o    (press_o),
    .release_o  (release_o),
    .long_o     (long_o),
    .repeat_o   (repeat_o),
    .held_o     (held_o),
    .press_cnt_o(press_cnt_o)
  );

  always #5 clk100_i = ~clk100_i;

  always @(negedge clk100_i) begin
    if (!rstn_i && (int'(press_o) + int'(release_o) + int'(long_o) + int'(repeat_o) > 1))
      multi_n <= multi_n + 1;
  end

  task automatic tick;
    @(posedge clk100_i);
    #1;
  endtask

  task automatic scan_clear;
    idx = 0; p_n = 0; p_at = -1; r_n = 0; r_at = -1; l_n = 0; l_at = -1;
    rep_n = 0; rep_at1 = -1; rep_at2 = -1; h_n = 0;
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      idx++;
      if (press_o) begin p_n++; if (p_at < 0) p_at = idx; end
      if (release_o) begin r_n++; if (r_at < 0) r_at = idx; end
      if (long_o) begin l_n++; if (l_at < 0) l_at = idx; end
      if (repeat_o) begin
        rep_n++;
        if (rep_n == 1) rep_at1 = idx;
        if (rep_n == 2) rep_at2 = idx;
      end
      if (held_o) h_n++;
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b1; key_ni = 1'b1; clr_i = 1'b0;
    #3;
    total++;
    if ({press_o, release_o, long_o, repeat_o, held_o, press_cnt_o} !== 13'b0) begin
      bad++; $display("FAIL reset_init: got %b want 0",
        {press_o, release_o, long_o, repeat_o, held_o, press_cnt_o});
    end
    tick(); tick();
    rstn_i = 1'b0;
    tick(); tick();
    key_ni = 1'b0;
    scan_clear(); scan(12);
    total++;
    if (held_o !== 1'b1 || press_cnt_o !== 8'd1) begin
      bad++; $display("FAIL reset_prehold: held=%b cnt=%0d want 1/1", held_o, press_cnt_o);
    end
    #2; rstn_i = 1'b1; #1;
    total++;
    if ({press_o, release_o, long_o, repeat_o, held_o, press_cnt_o} !== 13'b0) begin
      bad++; $display("FAIL reset_async: got %b want 0",
        {press_o, release_o, long_o, repeat_o, held_o, press_cnt_o});
    end
    tick(); tick();
    rstn_i = 1'b0;
    scan_clear(); scan(15);
    total++;
    if (p_n !== 1 || p_at !== 6) begin
      bad++; $display("FAIL reset_requalify: presses=%0d at=%0d want 1 at 6", p_n, p_at);
    end
    key_ni = 1'b1;
    scan_clear(); scan(10);
    total++;
    if (r_n !== 1 || r_at !== 6 || held_o !== 1'b0) begin
      bad++; $display("FAIL reset_release: n=%0d at=%0d held=%b want 1 at 6 held 0",
        r_n, r_at, held_o);
    end
  endtask

  task automatic test_bounce_and_press;
    int n1;
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    total++;
    if (press_cnt_o !== 8'd0) begin
      bad++; $display("FAIL clr_idle: cnt=%0d want 0", press_cnt_o);
    end
    key_ni = 1'b0;
    scan_clear(); scan(3);
    n1 = p_n;
    key_ni = 1'b1;
    scan_clear(); scan(12);
    total++;
    if (n1 + p_n !== 0 || press_cnt_o !== 8'd0) begin
      bad++; $display("FAIL bounce_reject: presses=%0d cnt=%0d want 0/0", n1 + p_n, press_cnt_o);
    end
    key_ni = 1'b0;
    scan_clear(); scan(10);
    total++;
    if (p_n !== 1 || p_at !== 6 || press_cnt_o !== 8'd1 || h_n !== 5) begin
      bad++; $display("FAIL press_10: n=%0d at=%0d cnt=%0d held_ticks=%0d want 1/6/1/5",
        p_n, p_at, press_cnt_o, h_n);
    end
    key_ni = 1'b1;
    scan_clear(); scan(12);
    total++;
    if (r_n !== 1 || r_at !== 6 || h_n !== 5 || held_o !== 1'b0) begin
      bad++; $display("FAIL release_10: n=%0d at=%0d held_ticks=%0d held=%b want 1/6/5/0",
        r_n, r_at, h_n, held_o);
    end
  endtask

  task automatic test_long;
    key_ni = 1'b0;
    scan_clear(); scan(46);
    total++;
    if (p_at !== 6 || l_n !== 1 || l_at !== 26 || r_n !== 0) begin
      bad++; $display("FAIL long_timing: press=%0d long=%0d(n%0d) rel=%0d want 6/26(n1)/0",
        p_at, l_at, l_n, r_n);
    end
    total++;
    if (rep_at1 !== 31 || rep_at2 !== 36 || rep_n !== 4) begin
      bad++; $display("FAIL repeat_timing: r1=%0d r2=%0d n=%0d want 31/36/4",
        rep_at1, rep_at2, rep_n);
    end
    key_ni = 1'b1;
    scan_clear(); scan(12);
    total++;
    if (r_n !== 1 || r_at !== 6 || held_o !== 1'b0) begin
      bad++; $display("FAIL long_release: n=%0d at=%0d held=%b want 1/6/0", r_n, r_at, held_o);
    end
  endtask

  task automatic test_glitch;
    key_ni = 1'b0;
    scan_clear(); scan(10);
    key_ni = 1'b1; scan(2);
    key_ni = 1'b0; scan(30);
    total++;
    if (p_n !== 1 || r_n !== 0 || l_at !== 28) begin
      bad++; $display("FAIL glitch_long: presses=%0d rel=%0d long=%0d want 1/0/28",
        p_n, r_n, l_at);
    end
    total++;
    if (rep_at1 !== 33 || rep_at2 !== 38) begin
      bad++; $display("FAIL glitch_repeat: r1=%0d r2=%0d want 33/38", rep_at1, rep_at2);
    end
    key_ni = 1'b1;
    scan_clear(); scan(12);
  endtask

  task automatic test_wrap;
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    scan_clear();
    for (int i = 0; i < 256; i++) begin
      key_ni = 1'b0; scan(8);
      key_ni = 1'b1; scan(8);
      if (i == 254) begin
        total++;
        if (press_cnt_o !== 8'd255) begin
          bad++; $display("FAIL wrap_255: cnt=%0d want 255", press_cnt_o);
        end
      end
    end
    total++;
    if (press_cnt_o !== 8'd0 || p_n !== 256 || r_n !== 256) begin
      bad++; $display("FAIL wrap_256: cnt=%0d presses=%0d rels=%0d want 0/256/256",
        press_cnt_o, p_n, r_n);
    end
  endtask

  task automatic test_clr_same_edge;
    key_ni = 1'b0; scan_clear(); scan(8);
    key_ni = 1'b1; scan(8);
    total++;
    if (press_cnt_o !== 8'd1) begin
      bad++; $display("FAIL clr_pre: cnt=%0d want 1", press_cnt_o);
    end
    key_ni = 1'b0;
    repeat (5) tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    total++;
    if (press_o !== 1'b1 || press_cnt_o !== 8'd0) begin
      bad++; $display("FAIL clr_same_edge: press=%b cnt=%0d want 1/0", press_o, press_cnt_o);
    end
    tick();
    total++;
    if (press_cnt_o !== 8'd0 || held_o !== 1'b1) begin
      bad++; $display("FAIL clr_after: cnt=%0d held=%b want 0/1", press_cnt_o, held_o);
    end
    key_ni = 1'b1;
    scan_clear(); scan(10);
  endtask

  initial begin
    test_reset();
    test_bounce_and_press();
    test_long();
    test_glitch();
    test_wrap();
    test_clr_same_edge();
    total++;
    if (multi_n !== 0) begin
      bad++; $display("FAIL one_hot_events: overlapping cycles=%0d want 0", multi_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
